vec_store_unit: RTL and testbench
=================================

Name: vec_store_unit

Overview:
Write-side sequencer for the 5-lane vector path. It takes the vector that the vector ALU/regfile produces (lane_0..lane_4) plus a base address, and serialises it into single-word writes on the data-memory port using a req/ready handshake. While the transfer is in progress it stalls the single-cycle core, and it pulses done when the last write completes. It sits between the datapath's vector write-data outputs and the data-memory port arbiter.

Parameters:
DATA_W, 32, width of each lane and of the memory data bus
ADDR_W, 32, memory byte-address width
LANES, 5, number of vector lanes; fixed at 5 in this revision
STRIDE, 4, byte increment between consecutive lanes

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle request to store the vector; sampled only in IDLE
base_addr  input  ADDR_W  byte address of lane 0; bits [1:0] are forced to 0 internally
lane_mask  input  LANES  bit i = 1 means lane i is written; bit i = 0 means lane i is skipped
lane_0..lane_4  input  DATA_W each  vector lane data from the vector ALU
mem_req  output  1  write request valid
mem_we  output  1  write enable; equals mem_req
mem_addr  output  ADDR_W  write byte address
mem_wdata  output  DATA_W  write data
mem_ready  input  1  memory accepts the request this cycle
stall  output  1  freeze PC/regfile writes in the core
busy  output  1  unit is not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- States: IDLE, ISSUE, DONE (state encoding comes from the shared package).
- Reset (async, reset=0):
  - state goes to IDLE.
  - mem_req, mem_we, busy and done go to 0; mem_addr and mem_wdata go to 0.
  - Captured registers are cleared. Reset mid-transfer drops mem_req immediately, and the partial store is abandoned.
- IDLE:
  - stall = start (combinational), so the core holds on the start cycle.
  - On a clock edge with start=1: capture base_addr (with [1:0] forced to 00), lane_mask, and lane_0..4 into internal registers.
  - If the captured mask is nonzero: idx = lowest set mask bit, and go to ISSUE. If mask = 0: go directly to DONE.
- ISSUE:
  - mem_req = mem_we = 1.
  - mem_addr = base + STRIDE*idx, computed modulo 2^ADDR_W (wraps).
  - mem_wdata = captured lane[idx].
  - addr and data are held stable until accepted.
  - A transfer occurs on an edge where mem_req & mem_ready. After a transfer, idx advances to the next set mask bit above idx. If there is none, go to DONE.
  - With mem_ready=0, the state holds indefinitely; there is no timeout.
  - stall = 1 and busy = 1.
- DONE:
  - done = 1 for exactly one cycle; stall = 0, so the core retires the instruction this cycle.
  - busy = 1 and mem_req = 0.
  - Next state is IDLE unconditionally.
- Start handling:
  - start asserted in ISSUE or DONE is ignored; it is neither queued nor used to alter the captured data.
  - Live changes to the lane inputs after capture have no effect.
- Latency: with a full mask and mem_ready tied high, start is sampled at edge 0, the writes complete at edges 1..5, done is high in cycle 6, and the unit is in IDLE in cycle 7.
- Memory ordering: writes go out in strictly ascending lane order; a lane is never written twice.

Decomposition:
- Package vec_pkg holds:
  - VEC_LANES = 5
  - VEC_STRIDE = 4
  - state enum {VS_IDLE, VS_ISSUE, VS_DONE}
  - lane-index width constant (3 bits)
- Sub-module vec_next_lane: combinational priority encoder. Inputs are mask and current idx; outputs are the next set-bit index and a found flag. It is also used for the initial-lane search with idx = -1 semantics (the "first" input).

Test Plan:
- Full store: base=0x100, mask=11111, lanes=0xA0..0xA4, mem_ready=1 -> writes (0x100,0xA0), (0x104,0xA1), …, (0x110,0xA4) at cycles 1-5; done pulses at cycle 6; stall is high in cycles 0-5.
- Backpressure: mem_ready low for 3 cycles at each lane -> each addr/data pair is held stable until accepted; 5 writes total; done at cycle 21.
- Sparse mask 10101 with base=0x203 -> writes only to 0x200, 0x208, 0x210 with lanes 0, 2, 4; done 4 cycles after start.
- Zero mask: start with mask=00000 -> mem_req is never asserted; done in cycle 1; idle in cycle 2.
- Wrap: base=0xFFFFFFF8, full mask -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
- Reset and busy start:
  - reset=0 in the middle of the lane-2 request -> mem_req drops in the same cycle, no further writes, done never pulses.
  - start asserted during ISSUE -> ignored, with no extra writes.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants and types for the vector store path.
package vec_pkg;
    localparam int VEC_LANES  = 5;
    localparam int VEC_STRIDE = 4;
    localparam int VEC_IDX_W  = 3;

    typedef logic [VEC_IDX_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        VS_IDLE  = 2'd0,
        VS_ISSUE = 2'd1,
        VS_DONE  = 2'd2
    } vs_state_t;
endpackage

// File: rtl/vec_next_lane.sv
// Priority encoder: lowest set mask bit strictly above idx, or the lowest set bit when first=1.
module vec_next_lane
    import vec_pkg::*;
(
    input  logic [VEC_LANES-1:0] mask,
    input  lane_idx_t            idx,
    input  logic                 first,
    output lane_idx_t            next_idx,
    output logic                 found
);

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        // Scan downwards so the lowest qualifying lane is the one left standing.
        for (int i = VEC_LANES - 1; i >= 0; i--) begin
            if (mask[i] && (first || (lane_idx_t'(i) > idx))) begin
                next_idx = lane_idx_t'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_store_unit.sv
// Serialises a captured 5-lane vector into single-word memory writes, stalling the core meanwhile.
//   state    | meaning
//   VS_IDLE  | waiting for start; stall follows start
//   VS_ISSUE | presenting lane idx on the memory port until accepted
//   VS_DONE  | one-cycle done pulse, core released
module vec_store_unit
    import vec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LANES  = VEC_LANES,
    parameter int STRIDE = VEC_STRIDE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LANES-1:0]  lane_mask,
    input  logic [DATA_W-1:0] lane_0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic [DATA_W-1:0] lane_2,
    input  logic [DATA_W-1:0] lane_3,
    input  logic [DATA_W-1:0] lane_4,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              busy,
    output logic              done
);

    vs_state_t         state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LANES-1:0]  mask_q;
    logic [DATA_W-1:0] lane_q [VEC_LANES];
    lane_idx_t         idx_q;
    logic [DATA_W-1:0] lane_data;

    logic [LANES-1:0]  srch_mask;
    logic              srch_first;
    lane_idx_t         nl_idx;
    logic              nl_found;

    // In IDLE the encoder looks at the live mask for the first lane; afterwards it walks the captured one.
    assign srch_first = (state_q == VS_IDLE);
    assign srch_mask  = srch_first ? lane_mask : mask_q;

    vec_next_lane u_next_lane (
        .mask     (srch_mask),
        .idx      (idx_q),
        .first    (srch_first),
        .next_idx (nl_idx),
        .found    (nl_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= VS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            mask_q <= '0;
            idx_q  <= '0;
            for (int i = 0; i < VEC_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else if ((state_q == VS_IDLE) && start) begin
            base_q    <= base_addr & ~ADDR_W'(3);
            mask_q    <= lane_mask;
            idx_q     <= nl_idx;
            lane_q[0] <= lane_0;
            lane_q[1] <= lane_1;
            lane_q[2] <= lane_2;
            lane_q[3] <= lane_3;
            lane_q[4] <= lane_4;
        end else if ((state_q == VS_ISSUE) && mem_ready && nl_found) begin
            idx_q <= nl_idx;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    lane_data = lane_q[0];
            3'd1:    lane_data = lane_q[1];
            3'd2:    lane_data = lane_q[2];
            3'd3:    lane_data = lane_q[3];
            3'd4:    lane_data = lane_q[4];
            default: lane_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            VS_IDLE: begin
                stall = start;
                if (start) begin
                    state_d = nl_found ? VS_ISSUE : VS_DONE;
                end
            end
            VS_ISSUE: begin
                mem_req   = 1'b1;
                stall     = 1'b1;
                busy      = 1'b1;
                mem_addr  = base_q + ADDR_W'(idx_q) * ADDR_W'(STRIDE);
                mem_wdata = lane_data;
                if (mem_ready && !nl_found) begin
                    state_d = VS_DONE;
                end
            end
            VS_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = VS_IDLE;
            end
            default: state_d = VS_IDLE;
        endcase
    end

    assign mem_we = mem_req;

endmodule

// File: tb/tb_vec_store_unit.sv
// Scoreboard bench for vec_store_unit: directed plan cases plus randomized stores against a lane-list model.
module tb_vec_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [4:0]  lane_mask = '0;
    logic [31:0] lane_0 = '0, lane_1 = '0, lane_2 = '0, lane_3 = '0, lane_4 = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic        stall, busy, done;

    vec_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .lane_mask (lane_mask),
        .lane_0    (lane_0),
        .lane_1    (lane_1),
        .lane_2    (lane_2),
        .lane_3    (lane_3),
        .lane_4    (lane_4),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .stall     (stall),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;
    int          wait_cnt = 0;
    int          txn_id = 0;
    logic [31:0] tl [5];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // mode 0: always ready; 1: random; 2: each request waits 3 cycles before acceptance
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = 1'($urandom_range(0, 1));
            default: begin
                if (mem_req) begin
                    mem_ready = (wait_cnt == 3);
                    wait_cnt  = mem_ready ? 0 : wait_cnt + 1;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt  = 0;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mem_req) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
                end else begin
                    chk("wr_addr", mem_addr, exp_wr[0].addr);
                    chk("wr_data", mem_wdata, exp_wr[0].data);
                    chk("wr_we", 32'(mem_we), 32'd1);
                    if (mem_ready) void'(exp_wr.pop_front());
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    chk("writes_before_done", 32'(exp_wr.size()), 32'd0);
                    void'(exp_done.pop_front());
                end
            end
        end
    end

    task automatic model_push(input logic [31:0] base, input logic [4:0] mask);
        logic [31:0] b;
        b = base & 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) exp_wr.push_back('{addr: b + 32'(4 * i), data: tl[i]});
        end
        exp_done.push_back(txn_id);
        txn_id++;
    endtask

    task automatic randomize_lanes();
        lane_0 = $urandom; lane_1 = $urandom; lane_2 = $urandom;
        lane_3 = $urandom; lane_4 = $urandom;
    endtask

    task automatic run_txn(input logic [31:0] base, input logic [4:0] mask, input int mode,
                           input bit poke_start, input int exp_cycle);
        int cyc;
        int got;
        bit stall_ok;
        bit busy_ok;
        ready_mode = mode;
        model_push(base, mask);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        lane_mask = mask;
        lane_0 = tl[0]; lane_1 = tl[1]; lane_2 = tl[2]; lane_3 = tl[3]; lane_4 = tl[4];
        #1;
        chk("stall_on_start", 32'(stall), 32'd1);
        cyc = 0;
        got = -1;
        stall_ok = 1'b1;
        busy_ok = 1'b1;
        while (cyc < 300 && got < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            randomize_lanes();
            lane_mask = 5'($urandom);
            base_addr = $urandom;
            if (poke_start && cyc == 2) begin
                start = 1'b1;
                lane_mask = 5'h1F;
            end
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = cyc;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        start = 1'b0;
        if (got < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", cyc);
        end else if (exp_cycle >= 0) begin
            chk("done_cycle", 32'(got), 32'(exp_cycle));
        end
        chk("stall_pattern", 32'(stall_ok), 32'd1);
        chk("busy_pattern", 32'(busy_ok), 32'd1);
        @(posedge clk);
        #2;
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_transfer(input logic [31:0] base);
        int n;
        bit seen;
        for (int i = 0; i < 5; i++) tl[i] = 32'hC0 + 32'(i);
        ready_mode = 2;
        model_push(base, 5'h1F);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = base; lane_mask = 5'h1F;
        lane_0 = tl[0]; lane_1 = tl[1]; lane_2 = tl[2]; lane_3 = tl[3]; lane_4 = tl[4];
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (mem_req === 1'b1 && mem_addr === base + 32'd8) seen = 1'b1;
        end
        chk("lane2_reached", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        exp_wr.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [4:0]  m;
        logic [31:0] b;
        int mode;
        int pc;
        int exp_c;

        #12;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) tl[i] = 32'hA0 + 32'(i);
        run_txn(32'h100, 5'b11111, 0, 1'b0, 6);
        run_txn(32'h100, 5'b11111, 0, 1'b1, 6);
        run_txn(32'h400, 5'b11111, 2, 1'b0, 21);
        for (int i = 0; i < 5; i++) tl[i] = 32'hB0 + 32'(i);
        run_txn(32'h203, 5'b10101, 0, 1'b0, 4);
        run_txn(32'h500, 5'b00000, 0, 1'b0, 1);
        run_txn(32'hFFFF_FFF8, 5'b11111, 0, 1'b0, 6);
        reset_mid_transfer(32'h300);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 5; i++) tl[i] = $urandom;
            m    = 5'($urandom);
            b    = $urandom;
            mode = $urandom_range(0, 2);
            pc   = $countones(m);
            exp_c = (mode == 0) ? pc + 1 : (mode == 2) ? 4 * pc + 1 : -1;
            run_txn(b, m, mode, 1'($urandom_range(0, 1)) && (mode == 0) && (pc >= 2) && m[0], exp_c);
        end

        repeat (5) @(posedge clk);
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
        chk("dones_drained", 32'(exp_done.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
